reloj_mmss: RTL and testbench

RELOJ_MMSS -- requirements
Module: reloj_mmss

---
 rtl/reloj_pkg.sv | 41 ++++
 rtl/reloj_mmss_if.sv | 39 +++
 rtl/bcd_mod60.sv | 22 ++
 rtl/reloj_mmss.sv | 125 ++++++++++++
 tb/tb_reloj_mmss.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reloj_pkg.sv
// Shared types and constants for the mm:ss clock: FSM states, set-field codes,
// BCD digit limits and a BCD mod-60 increment helper.
package reloj_pkg;

   typedef enum logic [1:0] {
      ST_STOP    = 2'd0,
      ST_RUN     = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'b00;
   localparam logic [1:0] FIELD_MIN  = 2'b01;
   localparam logic [1:0] FIELD_SEC  = 2'b10;

   localparam logic [3:0] BCD_ONES_MAX = 4'd9;
   localparam logic [3:0] BCD_TENS_MAX = 4'd5;
   localparam logic [7:0] BCD_ZERO     = 8'h00;

   function automatic logic bcd_is_59(input logic [7:0] v);
      return (v[7:4] >= BCD_TENS_MAX) && (v[3:0] >= BCD_ONES_MAX);
   endfunction

   // Out-of-range digits are folded back to zero so the count can never
   // leave the legal BCD range.
   function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
      logic [3:0] ones;
      logic [3:0] tens;
      ones = v[3:0];
      tens = v[7:4];
      if (ones >= BCD_ONES_MAX) begin
         ones = 4'd0;
         if (tens >= BCD_TENS_MAX) tens = 4'd0;
         else                      tens = tens + 4'd1;
      end else begin
         ones = ones + 4'd1;
      end
      return {tens, ones};
   endfunction

endpackage

// File: rtl/reloj_mmss_if.sv
// Bus bundle between the mm:ss clock and its environment. The alarm signals
// exist only when RELOJ_MMSS_ALARM_EN is defined.
interface reloj_mmss_if;

   logic       segundo;
   logic       btn_start_stop;
   logic       btn_mode;
   logic       btn_inc;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic [1:0] set_field;
   logic       hour_pulse;
`ifdef RELOJ_MMSS_ALARM_EN
   logic [7:0] alarm_min;
   logic       alarm;

   modport master (
      output segundo, btn_start_stop, btn_mode, btn_inc, alarm_min,
      input  min_bcd, sec_bcd, running, set_field, hour_pulse, alarm
   );

   modport slave (
      input  segundo, btn_start_stop, btn_mode, btn_inc, alarm_min,
      output min_bcd, sec_bcd, running, set_field, hour_pulse, alarm
   );
`else
   modport master (
      output segundo, btn_start_stop, btn_mode, btn_inc,
      input  min_bcd, sec_bcd, running, set_field, hour_pulse
   );

   modport slave (
      input  segundo, btn_start_stop, btn_mode, btn_inc,
      output min_bcd, sec_bcd, running, set_field, hour_pulse
   );
`endif

endinterface

// File: rtl/bcd_mod60.sv
// Two-digit BCD modulo-60 counter; carry_out flags the 59 -> 00 wrap in the
// same cycle the increment is applied.
module bcd_mod60
   import reloj_pkg::*;
(
   input  logic       mclk,
   input  logic       reset,
   input  logic       inc,
   output logic [7:0] value,
   output logic       carry_out
);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values, independent of process ordering.
   always_ff @(posedge mclk) begin
      if (reset)    value <= BCD_ZERO;
      else if (inc) value <= bcd_inc60(value);
   end

   assign carry_out = inc && bcd_is_59(value);

endmodule

// File: rtl/reloj_mmss.sv
// Minutes:seconds clock with run/stop and manual set modes driven by a 1 s
// strobe. Optional alarm output enabled by RELOJ_MMSS_ALARM_EN.
module reloj_mmss
   import reloj_pkg::*;
(
   input logic         mclk,
   input logic         reset,
   reloj_mmss_if.slave bus
);

   state_t     state;
   state_t     state_nxt;
   logic       seg_q;
   logic       tick;
   logic       advance;
   logic       min_set_inc;
   logic       sec_set_inc;
   logic       sec_inc;
   logic       min_inc;
   logic       sec_carry;
   logic       min_carry;
   logic [7:0] sec_value;
   logic [7:0] min_value;
   logic       hour_q;
   logic       ss_p;
   logic       mode_p;
   logic       inc_p;

   // seg_q follows segundo even in reset, so a level already high at release
   // is not mistaken for a fresh edge.
   always_ff @(posedge mclk) begin
      seg_q <= bus.segundo;
      if (reset) tick <= 1'b0;
      else       tick <= bus.segundo & ~seg_q;
   end

   always_ff @(posedge mclk) begin
      if (reset) state <= ST_STOP;
      else       state <= state_nxt;
   end

   // Button priority: start_stop masks mode, mode masks inc.
   assign ss_p   = bus.btn_start_stop;
   assign mode_p = bus.btn_mode & ~bus.btn_start_stop;
   assign inc_p  = bus.btn_inc & ~bus.btn_mode & ~bus.btn_start_stop;

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      min_set_inc = 1'b0;
      sec_set_inc = 1'b0;
      case (state)
         ST_STOP: begin
            if (ss_p)        state_nxt = ST_RUN;
            else if (mode_p) state_nxt = ST_SET_MIN;
         end
         ST_RUN: begin
            if (ss_p) state_nxt = ST_STOP;
         end
         ST_SET_MIN: begin
            if (mode_p)      state_nxt   = ST_SET_SEC;
            else if (inc_p)  min_set_inc = 1'b1;
         end
         ST_SET_SEC: begin
            if (mode_p)      state_nxt   = ST_STOP;
            else if (inc_p)  sec_set_inc = 1'b1;
         end
         default: state_nxt = ST_STOP;
      endcase
   end

   // Manual minute increments never carry; only running seconds roll over.
   assign advance = (state == ST_RUN) && tick;
   assign sec_inc = advance | sec_set_inc;
   assign min_inc = (advance & sec_carry) | min_set_inc;

   bcd_mod60 u_sec (
      .mclk      (mclk),
      .reset     (reset),
      .inc       (sec_inc),
      .value     (sec_value),
      .carry_out (sec_carry)
   );

   bcd_mod60 u_min (
      .mclk      (mclk),
      .reset     (reset),
      .inc       (min_inc),
      .value     (min_value),
      .carry_out (min_carry)
   );

   always_ff @(posedge mclk) begin
      if (reset) hour_q <= 1'b0;
      else       hour_q <= advance & sec_carry & min_carry;
   end

   always_comb begin
      bus.set_field = FIELD_NONE;
      case (state)
         ST_SET_MIN: bus.set_field = FIELD_MIN;
         ST_SET_SEC: bus.set_field = FIELD_SEC;
         default:    bus.set_field = FIELD_NONE;
      endcase
   end

   assign bus.min_bcd    = min_value;
   assign bus.sec_bcd    = sec_value;
   assign bus.running    = (state == ST_RUN);
   assign bus.hour_pulse = hour_q;

`ifdef RELOJ_MMSS_ALARM_EN
   logic alarm_q;

   // Fires on the edge where the running count lands on alarm_min:00.
   always_ff @(posedge mclk) begin
      if (reset) alarm_q <= 1'b0;
      else       alarm_q <= advance & sec_carry & (bcd_inc60(min_value) == bus.alarm_min);
   end

   assign bus.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_reloj_mmss.sv
// Scoreboard bench for reloj_mmss: stimulus queues every expected output
// snapshot, a negedge monitor pops one per observed output change.
module tb_reloj_mmss;

   typedef struct packed {
      logic [7:0] m;
      logic [7:0] s;
      logic       run;
      logic [1:0] sf;
      logic       hp;
   } snap_t;

   typedef struct {
      snap_t v;
      string tag;
   } expect_t;

   logic mclk;
   logic reset;
   bit   armed;
   int   n_checks;
   int   n_fail;
   int   cur_min;
   int   cur_sec;
   expect_t exp_q[$];

   reloj_mmss_if bus ();

   reloj_mmss dut (
      .mclk  (mclk),
      .reset (reset),
      .bus   (bus)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

`ifdef RELOJ_MMSS_ALARM_EN
   initial bus.alarm_min = 8'h30;
`endif

   function automatic logic [7:0] to_bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic push(input string tag, input int m, input int s, input bit run,
                       input logic [1:0] sf, input bit hp);
      expect_t e;
      e.v   = {to_bcd(m), to_bcd(s), run, sf, hp};
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge mclk);
         #1;
      end
   endtask

   task automatic press(input bit ss, input bit md, input bit inc);
      bus.btn_start_stop = ss;
      bus.btn_mode       = md;
      bus.btn_inc        = inc;
      step(1);
      bus.btn_start_stop = 1'b0;
      bus.btn_mode       = 1'b0;
      bus.btn_inc        = 1'b0;
   endtask

   task automatic sec_tick();
      bus.segundo = 1'b1;
      step(3);
      bus.segundo = 1'b0;
      step(2);
   endtask

   task automatic set_time(input int tm, input int ts);
      push("set_min_enter", cur_min, cur_sec, 0, 2'b01, 0);
      press(0, 1, 0);
      while (cur_min != tm) begin
         cur_min = (cur_min + 1) % 60;
         push("set_min_inc", cur_min, cur_sec, 0, 2'b01, 0);
         press(0, 0, 1);
      end
      push("set_sec_enter", cur_min, cur_sec, 0, 2'b10, 0);
      press(0, 1, 0);
      while (cur_sec != ts) begin
         cur_sec = (cur_sec + 1) % 60;
         push("set_sec_inc", cur_min, cur_sec, 0, 2'b10, 0);
         press(0, 0, 1);
      end
      push("set_exit", cur_min, cur_sec, 0, 2'b00, 0);
      press(0, 1, 0);
   endtask

   // Monitor: every change of the output bundle consumes one expectation.
   initial begin
      snap_t   cur;
      snap_t   prev;
      expect_t e;
      bit      have_prev;
      int      hp_width;
      have_prev = 1'b0;
      hp_width  = 0;
      prev      = '0;
      wait (armed);
      forever begin
         @(negedge mclk);
         cur = {bus.min_bcd, bus.sec_bcd, bus.running, bus.set_field, bus.hour_pulse};
         if (cur.hp) begin
            hp_width++;
         end else if (have_prev && prev.hp) begin
            n_checks++;
            if (hp_width != 1) begin
               n_fail++;
               $display("FAIL hour_pulse_width: got %0d cycles, want 1", hp_width);
            end
            hp_width = 0;
         end
         if (!have_prev || cur !== prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change: got min=%h sec=%h run=%0b sf=%b hp=%0b",
                        cur.m, cur.s, cur.run, cur.sf, cur.hp);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e.v) begin
                  n_fail++;
                  $display("FAIL %s: got min=%h sec=%h run=%0b sf=%b hp=%0b, want min=%h sec=%h run=%0b sf=%b hp=%0b",
                           e.tag, cur.m, cur.s, cur.run, cur.sf, cur.hp,
                           e.v.m, e.v.s, e.v.run, e.v.sf, e.v.hp);
               end
            end
         end
         prev      = cur;
         have_prev = 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks           = 0;
      n_fail             = 0;
      armed              = 1'b0;
      reset              = 1'b1;
      bus.segundo        = 1'b0;
      bus.btn_start_stop = 1'b0;
      bus.btn_mode       = 1'b0;
      bus.btn_inc        = 1'b0;
      repeat (3) @(posedge mclk);
      #1;
      reset = 1'b0;
      push("reset_state", 0, 0, 0, 2'b00, 0);
      armed = 1'b1;
      step(2);

      // Three seconds of running from reset.
      push("start", 0, 0, 1, 2'b00, 0);
      press(1, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         push("run_tick", 0, i, 1, 2'b00, 0);
         sec_tick();
      end
      push("stop", 0, 3, 0, 2'b00, 0);
      press(1, 0, 0);
      cur_min = 0;
      cur_sec = 3;
      press(0, 0, 1);
      sec_tick();

      // Minute set wraps without carry; start_stop ignored while setting.
      push("set_min_enter", 0, 3, 0, 2'b01, 0);
      press(0, 1, 0);
      for (int i = 1; i <= 61; i++) begin
         push("set_min_wrap", i % 60, 3, 0, 2'b01, 0);
         press(0, 0, 1);
      end
      press(1, 0, 0);
      sec_tick();
      push("set_sec_enter", 1, 3, 0, 2'b10, 0);
      press(0, 1, 0);
      push("set_sec_inc", 1, 4, 0, 2'b10, 0);
      press(0, 0, 1);
      press(1, 0, 0);
      push("mode_beats_inc", 1, 4, 0, 2'b00, 0);
      press(0, 1, 1);
      cur_min = 1;
      cur_sec = 4;

      // 00:59 -> 01:00 carries into minutes, no hour pulse.
      set_time(0, 59);
      push("start_0059", 0, 59, 1, 2'b00, 0);
      press(1, 0, 0);
      press(0, 1, 1);
      push("carry_0100", 1, 0, 1, 2'b00, 0);
      sec_tick();
      push("stop_0100", 1, 0, 0, 2'b00, 0);
      press(1, 0, 0);
      cur_min = 1;
      cur_sec = 0;

      // 59:59 -> 00:00 raises a single-cycle hour pulse.
      set_time(59, 59);
      push("start_5959", 59, 59, 1, 2'b00, 0);
      press(1, 0, 0);
      push("hour_rise", 0, 0, 1, 2'b00, 1);
      push("hour_fall", 0, 0, 1, 2'b00, 0);
      sec_tick();
      push("after_hour", 0, 1, 1, 2'b00, 0);
      sec_tick();

      // Tick and start_stop in the same cycle: count advances then stops.
      push("tick_and_stop", 0, 2, 0, 2'b00, 0);
      bus.segundo = 1'b1;
      step(1);
      press(1, 0, 0);
      bus.segundo = 1'b0;
      step(2);
      sec_tick();
      sec_tick();

      // Reset mid-count overrides buttons; segundo held high through release.
      push("restart", 0, 2, 1, 2'b00, 0);
      press(1, 0, 0);
      push("pre_reset_tick", 0, 3, 1, 2'b00, 0);
      sec_tick();
      push("mid_run_reset", 0, 0, 0, 2'b00, 0);
      bus.segundo        = 1'b1;
      bus.btn_start_stop = 1'b1;
      bus.btn_inc        = 1'b1;
      reset              = 1'b1;
      step(2);
      reset              = 1'b0;
      bus.btn_start_stop = 1'b0;
      bus.btn_inc        = 1'b0;
      step(3);
      push("run_after_reset", 0, 0, 1, 2'b00, 0);
      press(1, 0, 0);
      step(4);
      bus.segundo = 1'b0;
      step(2);
      push("first_real_tick", 0, 1, 1, 2'b00, 0);
      sec_tick();

      step(6);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
